li_expander: RTL and testbench

- Encoder-side counterpart to the decode path's immediate extraction. Takes a destination register and a 32-bit constant, and emits the minimal RISC-V RV32I instruction sequence that loads that constant: ADDI alone, LUI alone, or LUI followed by ADDI.
- Used by the boot/test-program generator and the debug instruction-injection path to feed instruction words into the fetch stream.
- Valid/ready stream on both sides.

---
 rtl/li_expander_if.sv | 25 ++
 rtl/li_expander.sv | 95 +++++++++
 tb/tb_li_expander.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/li_expander_if.sv
// Request/response stream bundle for the load-immediate expander.
// master drives requests and consumes instructions; slave is the expander.
interface li_expander_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rd;
  logic [31:0]      in_value;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             out_last;
  logic [CNT_W-1:0] inst_count;

  modport master (
    output in_valid, in_rd, in_value, out_ready,
    input  in_ready, out_valid, out_inst, out_last, inst_count
  );

  modport slave (
    input  in_valid, in_rd, in_value, out_ready,
    output in_ready, out_valid, out_inst, out_last, inst_count
  );
endinterface

// File: rtl/li_expander.sv
// Load-immediate expander: turns (rd, 32-bit constant) into the shortest
// RV32I sequence (ADDI, LUI, or LUI+ADDI) on a valid/ready output stream.
module li_expander #(
  parameter bit          NOP_ON_X0 = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic           clk,
  input  logic           rst,
  li_expander_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StEmit1, StEmit2} state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [31:0]      out_inst_q;
  logic [31:0]      addi_q;
  logic [CNT_W-1:0] cnt_q;

  logic [11:0] lo;
  logic [19:0] hi;
  logic        fits;
  logic [31:0] first_word;
  logic [31:0] second_word;
  logic        two_words;
  logic        accept;
  logic        xfer;

  // Field derivation and case selection on the request currently offered.
  always_comb begin
    lo = bus.in_value[11:0];
    // Adding 0x800 carries into bit 12 exactly when bit 11 is set.
    hi = bus.in_value[31:12] + {19'd0, bus.in_value[11]};
    fits = (&bus.in_value[31:11]) | ~(|bus.in_value[31:11]);
    second_word = {lo, bus.in_rd, 3'b000, bus.in_rd, 7'b0010011};
    two_words = 1'b0;
    if (NOP_ON_X0 && (bus.in_rd == 5'd0)) begin
      first_word = 32'h0000_0013;
    end else if (fits) begin
      first_word = {lo, 5'd0, 3'b000, bus.in_rd, 7'b0010011};
    end else if (lo == 12'd0) begin
      first_word = {hi, bus.in_rd, 7'b0110111};
    end else begin
      first_word = {hi, bus.in_rd, 7'b0110111};
      two_words  = 1'b1;
    end
  end

  // Accept when idle, or when the final word of the current request leaves.
  always_comb begin
    bus.in_ready = (state_q == StIdle) || (out_valid_q && bus.out_ready && out_last_q);
    accept       = bus.in_valid && bus.in_ready;
    xfer         = out_valid_q && bus.out_ready;
  end

  // Sequencer with registered outputs and transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_inst_q  <= 32'd0;
      addi_q      <= 32'd0;
      cnt_q       <= '0;
    end else begin
      if (xfer) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (accept) begin
        state_q     <= StEmit1;
        out_valid_q <= 1'b1;
        out_inst_q  <= first_word;
        out_last_q  <= ~two_words;
        addi_q      <= second_word;
      end else if (xfer) begin
        if (!out_last_q) begin
          state_q    <= StEmit2;
          out_inst_q <= addi_q;
          out_last_q <= 1'b1;
        end else begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_inst   = out_inst_q;
  assign bus.out_last   = out_last_q;
  assign bus.inst_count = cnt_q;

endmodule

// File: tb/tb_li_expander.sv
// Self-checking bench for li_expander: directed vectors plus random requests
// checked against an arithmetic reference model.
module tb_li_expander;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [15:0] exp_cnt;

  li_expander_if #(.CNT_W(16)) bus ();

  li_expander #(
    .NOP_ON_X0(1'b1),
    .CNT_W    (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_addi(input logic [31:0] rd, input logic [31:0] rs1,
                                           input logic [31:0] imm);
    return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
  endfunction

  function automatic logic [31:0] enc_lui(input logic [31:0] rd, input logic [31:0] imm20);
    return (imm20 << 12) | (rd << 7) | 32'h37;
  endfunction

  // Reference: constant fits a signed 12-bit immediate -> ADDI; else split
  // into rounded upper part and low 12 bits.
  task automatic model(input logic [4:0] rd, input logic [31:0] v,
                       output logic [31:0] w0, output logic [31:0] w1, output int n);
    int signed   sv;
    logic [31:0] r;
    logic [31:0] hi;
    logic [31:0] lo;
    sv = $signed(v);
    r  = {27'd0, rd};
    w1 = 32'd0;
    n  = 1;
    if (rd == 5'd0) begin
      w0 = 32'h13;
    end else if (sv >= -2048 && sv <= 2047) begin
      w0 = enc_addi(r, 0, v);
    end else begin
      hi = (v + 32'h800) >> 12;
      lo = v & 32'hFFF;
      w0 = enc_lui(r, hi);
      if (lo != 0) begin
        w1 = enc_addi(r, r, lo);
        n  = 2;
      end
    end
  endtask

  // One request from idle, with optional stall on its first word.
  task automatic do_req(input logic [4:0] rd, input logic [31:0] v, input int stall,
                        input logic [31:0] w0, input logic [31:0] w1, input int n);
    logic [31:0] w;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_rd    = rd;
    bus.in_value = v;
    bus.out_ready = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_rd    = 5'($urandom);
    bus.in_value = $urandom;
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      if (i == 0) begin
        for (int s = 0; s < stall; s++) begin
          bus.out_ready = 1'b0;
          #1;
          chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
          chk("stall_inst", bus.out_inst, w);
          chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
          @(negedge clk);
        end
      end
      bus.out_ready = 1'b1;
      #1;
      chk("out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("out_inst", bus.out_inst, w);
      chk("out_last", {31'd0, bus.out_last}, (i == n - 1) ? 32'd1 : 32'd0);
      chk("xfer_in_ready", {31'd0, bus.in_ready}, (i == n - 1) ? 32'd1 : 32'd0);
      chk("count_before", {16'd0, bus.inst_count}, {16'd0, exp_cnt});
      @(posedge clk);
      exp_cnt++;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    #1;
    chk("done_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("done_count", {16'd0, bus.inst_count}, {16'd0, exp_cnt});
  endtask

  task automatic rand_req(input int stall);
    logic [4:0]  rd;
    logic [31:0] v;
    logic [31:0] w0;
    logic [31:0] w1;
    int          n;
    rd = 5'($urandom);
    case ($urandom_range(0, 4))
      0: v = $urandom;
      1: v = 32'($urandom_range(0, 4095)) - 32'd2048;
      2: v = $urandom & 32'hFFFF_F000;
      3: v = ($urandom & 32'hFFFF_F000) | 32'h800;
      default: v = 32'($urandom_range(0, 8191)) - 32'd4096;
    endcase
    model(rd, v, w0, w1, n);
    do_req(rd, v, stall, w0, w1, n);
  endtask

  initial begin
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] prev;
    logic [4:0]  rd;
    logic [31:0] v;
    int          n;
    checks  = 0;
    errors  = 0;
    exp_cnt = 16'd0;
    rst     = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_rd     = 5'd0;
    bus.in_value  = 32'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_inst", bus.out_inst, 32'd0);
    chk("rst_last", {31'd0, bus.out_last}, 32'd0);
    chk("rst_count", {16'd0, bus.inst_count}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Directed vectors with hand-derived encodings.
    do_req(5'd1, 32'h0000_0005, 0, 32'h0050_0093, 32'd0, 1);
    do_req(5'd2, 32'h1234_5000, 0, 32'h1234_5137, 32'd0, 1);
    do_req(5'd5, 32'h1234_5678, 0, 32'h1234_52B7, 32'h6782_8293, 2);
    do_req(5'd1, 32'h0000_0800, 0, 32'h0000_10B7, 32'h8000_8093, 2);
    do_req(5'd1, 32'hFFFF_F800, 0, 32'h8000_0093, 32'd0, 1);
    do_req(5'd3, 32'h7FFF_F800, 0, 32'h8000_01B7, 32'h8001_8193, 2);
    do_req(5'd0, 32'h1234_5678, 0, 32'h0000_0013, 32'd0, 1);
    do_req(5'd5, 32'h1234_5678, 3, 32'h1234_52B7, 32'h6782_8293, 2);

    // Reset while the second word is pending: it must never appear.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_rd     = 5'd5;
    bus.in_value  = 32'h1234_5678;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("rst_seq_w0", bus.out_inst, 32'h1234_52B7);
    @(posedge clk);
    exp_cnt++;
    @(negedge clk);
    #1;
    chk("rst_seq_w1", bus.out_inst, 32'h6782_8293);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'd0;
    #1;
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_count", {16'd0, bus.inst_count}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("midrst_quiet", {31'd0, bus.out_valid}, 32'd0);
    end

    // Back-to-back single-word requests at full rate.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    prev = 32'd0;
    for (int k = 0; k < 8; k++) begin
      rd = 5'($urandom);
      v  = (k % 2 == 0) ? (32'($urandom_range(0, 4095)) - 32'd2048) : ($urandom & 32'hFFFF_F000);
      model(rd, v, w0, w1, n);
      bus.in_rd    = rd;
      bus.in_value = v;
      #1;
      chk("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
      if (k > 0) begin
        chk("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("b2b_inst", bus.out_inst, prev);
        chk("b2b_last", {31'd0, bus.out_last}, 32'd1);
        chk("b2b_count", {16'd0, bus.inst_count}, {16'd0, exp_cnt});
      end
      @(posedge clk);
      if (k > 0) exp_cnt++;
      prev = w0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    chk("b2b_tail_inst", bus.out_inst, prev);
    @(posedge clk);
    exp_cnt++;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    chk("b2b_tail_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("b2b_tail_count", {16'd0, bus.inst_count}, {16'd0, exp_cnt});

    // Random requests against the reference model.
    for (int r = 0; r < 40; r++) begin
      rand_req(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
